// File: rtl/bus_atomic_unit.sv
// Bus front-end that runs plain accesses and RISC-V LR/SC/AMO requests against a single
// memory port, holding one LR reservation per hart id.
module bus_atomic_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  input  logic        i_atomic,
  input  logic [6:0]  i_operation,
  input  logic        i_id,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
  output logic        o_mem_en,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wr_data,
  output logic [3:0]  o_mem_byte_en,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rd_data
);

  // state   | meaning
  // IDLE    | waiting for i_bus_en
  // PASS    | plain read/write in flight
  // AMO_RD  | atomic read (LR, AMO, unsupported funct5) in flight
  // AMO_WR  | atomic write (AMO result or SC data) in flight
  // SC_FAIL | SC without matching reservation, no memory access
  // DONE    | one-cycle o_ack with response data
  typedef enum logic [2:0] {IDLE, PASS, AMO_RD, AMO_WR, SC_FAIL, DONE} state_t;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  state_t      state_q, state_d;
  logic        req_wr_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_data_q;
  logic [3:0]  req_be_q;
  logic        req_atomic_q;
  logic [4:0]  req_f5_q;
  logic        req_id_q;
  logic [31:0] rsp_q;

  logic [1:0]       resv_vld_q, resv_vld_d;
  logic [1:0][29:0] resv_addr_q, resv_addr_d;

  logic [4:0]  in_f5;
  logic        resv_hit;
  logic [31:0] amo_result;
  logic        amo_writes;
  logic [31:0] wr_word;
  logic        mem_en;
  logic        wr_done, lr_done, sc_done;
  logic        unused_aqrl;

  assign in_f5       = i_operation[6:2];
  assign unused_aqrl = ^i_operation[1:0];
  assign resv_hit    = resv_vld_q[i_id] && (resv_addr_q[i_id] == i_addr[31:2]);

  // rsp_q holds the old memory word while in AMO_WR
  always_comb begin
    amo_result = req_data_q;
    amo_writes = 1'b1;
    case (req_f5_q)
      F_SWAP:  amo_result = req_data_q;
      F_ADD:   amo_result = rsp_q + req_data_q;
      F_XOR:   amo_result = rsp_q ^ req_data_q;
      F_AND:   amo_result = rsp_q & req_data_q;
      F_OR:    amo_result = rsp_q | req_data_q;
      F_MIN:   amo_result = ($signed(rsp_q) < $signed(req_data_q)) ? rsp_q : req_data_q;
      F_MAX:   amo_result = ($signed(rsp_q) > $signed(req_data_q)) ? rsp_q : req_data_q;
      F_MINU:  amo_result = (rsp_q < req_data_q) ? rsp_q : req_data_q;
      F_MAXU:  amo_result = (rsp_q > req_data_q) ? rsp_q : req_data_q;
      default: amo_writes = 1'b0;
    endcase
  end

  assign wr_word = (req_f5_q == F_SC) ? req_data_q : amo_result;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_bus_en) begin
          if (!i_atomic)             state_d = PASS;
          else if (in_f5 != F_SC)    state_d = AMO_RD;
          else if (resv_hit)         state_d = AMO_WR;
          else                       state_d = SC_FAIL;
        end
      end
      PASS:    if (i_mem_ack) state_d = DONE;
      AMO_RD:  if (i_mem_ack) state_d = amo_writes ? AMO_WR : DONE;
      AMO_WR:  if (i_mem_ack) state_d = DONE;
      SC_FAIL: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en        = (state_q == PASS) || (state_q == AMO_RD) || (state_q == AMO_WR);
  assign o_mem_en      = mem_en;
  assign o_mem_wr      = ((state_q == PASS) && req_wr_q) || (state_q == AMO_WR);
  assign o_mem_addr    = !mem_en ? 32'h0 :
                         req_atomic_q ? {req_addr_q[31:2], 2'b00} : req_addr_q;
  assign o_mem_byte_en = !mem_en ? 4'h0 : (req_atomic_q ? 4'hF : req_be_q);
  assign o_mem_wr_data = (state_q == PASS)   ? req_data_q :
                         (state_q == AMO_WR) ? wr_word : 32'h0;
  assign o_ack         = (state_q == DONE);
  assign o_rd_data     = o_ack ? rsp_q : 32'h0;

  assign wr_done = i_mem_ack && (((state_q == PASS) && req_wr_q) || (state_q == AMO_WR));
  assign lr_done = i_mem_ack && (state_q == AMO_RD) && (req_f5_q == F_LR);
  assign sc_done = (state_q == SC_FAIL) ||
                   (i_mem_ack && (state_q == AMO_WR) && (req_f5_q == F_SC));

  // a write snoops both harts' reservations; the SC clear covers the hart's own one
  always_comb begin
    resv_vld_d  = resv_vld_q;
    resv_addr_d = resv_addr_q;
    if (wr_done && (resv_addr_q[0] == req_addr_q[31:2])) resv_vld_d[0] = 1'b0;
    if (wr_done && (resv_addr_q[1] == req_addr_q[31:2])) resv_vld_d[1] = 1'b0;
    if (sc_done) resv_vld_d[req_id_q] = 1'b0;
    if (lr_done) begin
      resv_vld_d[req_id_q]  = 1'b1;
      resv_addr_d[req_id_q] = req_addr_q[31:2];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      req_wr_q     <= 1'b0;
      req_addr_q   <= 32'h0;
      req_data_q   <= 32'h0;
      req_be_q     <= 4'h0;
      req_atomic_q <= 1'b0;
      req_f5_q     <= 5'h0;
      req_id_q     <= 1'b0;
      rsp_q        <= 32'h0;
      resv_vld_q   <= 2'b00;
      resv_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      resv_vld_q  <= resv_vld_d;
      resv_addr_q <= resv_addr_d;
      if ((state_q == IDLE) && i_bus_en) begin
        req_wr_q     <= i_wr_en;
        req_addr_q   <= i_addr;
        req_data_q   <= i_wr_data;
        req_be_q     <= i_byte_en;
        req_atomic_q <= i_atomic;
        req_f5_q     <= in_f5;
        req_id_q     <= i_id;
      end
      case (state_q)
        PASS:    if (i_mem_ack) rsp_q <= i_mem_rd_data;
        AMO_RD:  if (i_mem_ack) rsp_q <= i_mem_rd_data;
        AMO_WR:  if (i_mem_ack && (req_f5_q == F_SC)) rsp_q <= 32'h0;
        SC_FAIL: rsp_q <= 32'h1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_atomic_unit.sv
// Bench for bus_atomic_unit: behavioural memory with programmable latency, a response
// scoreboard, a vector table and hand-written reset / bus_en-drop sequences.
module tb_bus_atomic_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_bus_en = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wr_data = 32'h0;
  logic [3:0]  i_byte_en = 4'h0;
  logic        i_atomic = 1'b0;
  logic [6:0]  i_operation = 7'h0;
  logic        i_id = 1'b0;
  logic        o_ack;
  logic [31:0] o_rd_data;
  logic        o_mem_en;
  logic        o_mem_wr;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wr_data;
  logic [3:0]  o_mem_byte_en;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rd_data = 32'h0;

  localparam logic [4:0] ADD = 5'b00000, SWAP = 5'b00001, LR = 5'b00010, SC = 5'b00011;
  localparam logic [4:0] XOR = 5'b00100, OR = 5'b01000, AND = 5'b01100, MIN = 5'b10000;
  localparam logic [4:0] MAX = 5'b10100, MINU = 5'b11000, MAXU = 5'b11100, BAD = 5'b00101;

  always #5 i_clk = ~i_clk;

  bus_atomic_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bus_en(i_bus_en), .i_wr_en(i_wr_en),
    .i_addr(i_addr), .i_wr_data(i_wr_data), .i_byte_en(i_byte_en), .i_atomic(i_atomic),
    .i_operation(i_operation), .i_id(i_id), .o_ack(o_ack), .o_rd_data(o_rd_data),
    .o_mem_en(o_mem_en), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
    .o_mem_wr_data(o_mem_wr_data), .o_mem_byte_en(o_mem_byte_en),
    .i_mem_ack(i_mem_ack), .i_mem_rd_data(i_mem_rd_data)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [logic [29:0]];
  int mem_lat = 1;
  int wait_cnt = 0;
  int mem_acc = 0;
  int ack_cnt = 0;
  logic [31:0] last_addr = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic [29:0] mw;
  logic [31:0] cur;
  logic [31:0] mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
  endfunction

  task automatic set_mem(input logic [31:0] a, input logic [31:0] v);
    mem[a[31:2]] = v;
  endtask

  // memory: acks after mem_lat cycles of o_mem_en, byte-lane writes
  always @(negedge i_clk) begin
    i_mem_ack = 1'b0;
    i_mem_rd_data = 32'h0;
    if (o_mem_en) begin
      if (wait_cnt >= mem_lat - 1) begin
        mw  = o_mem_addr[31:2];
        cur = mem.exists(mw) ? mem[mw] : 32'h0;
        if (o_mem_wr) begin
          for (int b = 0; b < 4; b++)
            if (o_mem_byte_en[b]) cur[8*b +: 8] = o_mem_wr_data[8*b +: 8];
          mem[mw] = cur;
        end else begin
          i_mem_rd_data = cur;
        end
        i_mem_ack = 1'b1;
        wait_cnt  = 0;
        mem_acc++;
        last_addr = o_mem_addr;
        last_be   = o_mem_byte_en;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(negedge i_clk) begin
    if (o_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: got o_ack=1 rd_data=0x%08h, expected no ack", o_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", o_rd_data, mon_e);
      end
    end else if (i_rst && o_rd_data !== 32'h0) begin
      checks++;
      $display("FAIL rd_data_idle: got 0x%08h, expected 0x0", o_rd_data);
    end
  end

  typedef struct {
    string       name;
    logic        atomic;
    logic [4:0]  f5;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        id;
    int          lat;
    logic        pre;
    logic [31:0] init;
    logic [31:0] exp_rd;
    logic [31:0] exp_mem;
    int          exp_acc;
    logic [31:0] exp_addr;
    int          exp_cyc;
  } vec_t;

  function automatic vec_t mk(string n, logic at, logic [4:0] f, logic w, logic [31:0] a,
                              logic [31:0] d, logic [3:0] be, logic id, int lat, logic pre,
                              logic [31:0] init, logic [31:0] er, logic [31:0] em, int acc,
                              logic [31:0] ea, int cyc);
    vec_t v;
    v.name = n; v.atomic = at; v.f5 = f; v.wr = w; v.addr = a; v.data = d; v.be = be;
    v.id = id; v.lat = lat; v.pre = pre; v.init = init; v.exp_rd = er; v.exp_mem = em;
    v.exp_acc = acc; v.exp_addr = ea; v.exp_cyc = cyc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_bus_en    = 1'b1;
    i_wr_en     = v.wr;
    i_addr      = v.addr;
    i_wr_data   = v.data;
    i_byte_en   = v.be;
    i_atomic    = v.atomic;
    i_operation = {v.f5, 2'($urandom_range(0, 3))};
    i_id        = v.id;
  endtask

  // exp_cyc counts falling edges from the accepting rising edge to the o_ack sample
  task automatic run(input vec_t v);
    int acc0, cyc;
    logic got;
    if (v.pre) set_mem(v.addr, v.init);
    mem_lat = v.lat;
    exp_q.push_back(v.exp_rd);
    acc0 = mem_acc;
    drive(v);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
      if (o_ack) got = 1'b1;
    end
    i_bus_en = 1'b0;
    chk({v.name, "_ack"}, got, 1'b1);
    chk({v.name, "_cycles"}, cyc, v.exp_cyc);
    chk({v.name, "_mem_accesses"}, mem_acc - acc0, v.exp_acc);
    chk({v.name, "_mem_word"}, rd_mem(v.addr), v.exp_mem);
    if (v.exp_acc > 0) begin
      chk({v.name, "_mem_addr"}, last_addr, v.exp_addr);
      chk({v.name, "_byte_en"}, last_be, v.atomic ? 4'hF : v.be);
    end
    @(negedge i_clk);
    chk({v.name, "_ack_one_cycle"}, o_ack, 1'b0);
  endtask

  vec_t vecs[$];
  vec_t hv;
  int   ack0, cyc;
  logic got;

  initial begin
    //              name           at f5    wr addr          data          be    id lat pre init          exp_rd        exp_mem       acc exp_addr      cyc
    vecs.push_back(mk("rd_plain",  0, ADD,  0, 32'h100, 32'h0,        4'h6, 0, 3, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 32'h100, 4));
    vecs.push_back(mk("lr_200",    1, LR,   0, 32'h200, 32'h0,        4'h0, 0, 2, 1, 32'h5,        32'h5,        32'h5,        1, 32'h200, 3));
    vecs.push_back(mk("sc_200_ok", 1, SC,   0, 32'h200, 32'h9,        4'h0, 0, 1, 0, 32'h0,        32'h0,        32'h9,        1, 32'h200, 2));
    vecs.push_back(mk("sc_200_2nd",1, SC,   0, 32'h200, 32'h7,        4'h0, 0, 1, 0, 32'h0,        32'h1,        32'h9,        0, 32'h0,   2));
    vecs.push_back(mk("lr_300",    1, LR,   0, 32'h300, 32'h0,        4'h0, 0, 1, 1, 32'h11,       32'h11,       32'h11,       1, 32'h300, 2));
    vecs.push_back(mk("st_300_id1",0, ADD,  1, 32'h300, 32'h22,       4'hF, 1, 2, 0, 32'h0,        32'h0,        32'h22,       1, 32'h300, 3));
    vecs.push_back(mk("sc_300",    1, SC,   0, 32'h300, 32'h33,       4'h0, 0, 1, 0, 32'h0,        32'h1,        32'h22,       0, 32'h0,   2));
    vecs.push_back(mk("amoadd",    1, ADD,  0, 32'h400, 32'h1,        4'h0, 0, 2, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        2, 32'h400, 5));
    vecs.push_back(mk("amomin",    1, MIN,  0, 32'h500, 32'h1,        4'h0, 0, 1, 1, 32'h80000000, 32'h80000000, 32'h80000000, 2, 32'h500, 3));
    vecs.push_back(mk("amominu",   1, MINU, 0, 32'h600, 32'h1,        4'h0, 0, 1, 1, 32'h80000000, 32'h80000000, 32'h1,        2, 32'h600, 3));
    vecs.push_back(mk("amomax",    1, MAX,  0, 32'h700, 32'h3,        4'h0, 1, 1, 1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h3,        2, 32'h700, 3));
    vecs.push_back(mk("amomaxu",   1, MAXU, 0, 32'h704, 32'h3,        4'h0, 1, 1, 1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 2, 32'h704, 3));
    vecs.push_back(mk("amoswap",   1, SWAP, 0, 32'h802, 32'h5555,     4'h3, 0, 2, 1, 32'hAAAA,     32'hAAAA,     32'h5555,     2, 32'h800, 5));
    vecs.push_back(mk("amoxor",    1, XOR,  0, 32'h804, 32'hFF00,     4'h0, 0, 1, 1, 32'hF0F0,     32'hF0F0,     32'h0FF0,     2, 32'h804, 3));
    vecs.push_back(mk("amoand",    1, AND,  0, 32'h808, 32'hFF00,     4'h0, 0, 1, 1, 32'hF0F0,     32'hF0F0,     32'hF000,     2, 32'h808, 3));
    vecs.push_back(mk("amoor",     1, OR,   0, 32'h80C, 32'hFF00,     4'h0, 0, 1, 1, 32'hF0F0,     32'hF0F0,     32'hFFF0,     2, 32'h80C, 3));
    vecs.push_back(mk("amo_bad",   1, BAD,  0, 32'h900, 32'h99,       4'h0, 0, 1, 1, 32'h1234,     32'h1234,     32'h1234,     1, 32'h900, 2));
    vecs.push_back(mk("lr_a00_id1",1, LR,   0, 32'hA00, 32'h0,        4'h0, 1, 1, 1, 32'h77,       32'h77,       32'h77,       1, 32'hA00, 2));
    vecs.push_back(mk("swap_a00",  1, SWAP, 0, 32'hA00, 32'h88,       4'h0, 0, 1, 0, 32'h0,        32'h77,       32'h88,       2, 32'hA00, 3));
    vecs.push_back(mk("sc_a00_id1",1, SC,   0, 32'hA00, 32'h99,       4'h0, 1, 1, 0, 32'h0,        32'h1,        32'h88,       0, 32'h0,   2));
    vecs.push_back(mk("lr_b00_id0",1, LR,   0, 32'hB00, 32'h0,        4'h0, 0, 1, 1, 32'h1,        32'h1,        32'h1,        1, 32'hB00, 2));
    vecs.push_back(mk("lr_b04_id1",1, LR,   0, 32'hB04, 32'h0,        4'h0, 1, 1, 1, 32'h2,        32'h2,        32'h2,        1, 32'hB04, 2));
    vecs.push_back(mk("st_b08",    0, ADD,  1, 32'hB08, 32'h3,        4'hF, 0, 1, 0, 32'h0,        32'h0,        32'h3,        1, 32'hB08, 2));
    vecs.push_back(mk("sc_b04_id1",1, SC,   0, 32'hB04, 32'h44,       4'h0, 1, 1, 0, 32'h0,        32'h0,        32'h44,       1, 32'hB04, 2));
    vecs.push_back(mk("sc_b00_id0",1, SC,   0, 32'hB00, 32'h55,       4'h0, 0, 3, 0, 32'h0,        32'h0,        32'h55,       1, 32'hB00, 4));
    vecs.push_back(mk("sc_b00_2nd",1, SC,   0, 32'hB00, 32'h66,       4'h0, 0, 1, 0, 32'h0,        32'h1,        32'h55,       0, 32'h0,   2));
    vecs.push_back(mk("lr_c00",    1, LR,   0, 32'hC00, 32'h0,        4'h0, 0, 1, 1, 32'hC0,       32'hC0,       32'hC0,       1, 32'hC00, 2));
    vecs.push_back(mk("lr_c10",    1, LR,   0, 32'hC13, 32'h0,        4'h0, 0, 1, 1, 32'hC1,       32'hC1,       32'hC1,       1, 32'hC10, 2));
    vecs.push_back(mk("sc_c00",    1, SC,   0, 32'hC00, 32'h5,        4'h0, 0, 1, 0, 32'h0,        32'h1,        32'hC0,       0, 32'h0,   2));
    vecs.push_back(mk("st_byte",   0, ADD,  1, 32'hD01, 32'h0000AB00, 4'h2, 0, 2, 1, 32'h11223344, 32'h0,        32'h1122AB44, 1, 32'hD01, 3));

    i_bus_en = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_outputs", {o_ack, o_mem_en, o_mem_wr, o_rd_data, o_mem_addr, o_mem_wr_data, o_mem_byte_en}, '0);
    i_bus_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);

    foreach (vecs[i]) run(vecs[i]);

    // i_bus_en dropped right after acceptance: the access still completes
    hv = mk("drop_en", 0, ADD, 0, 32'hE00, 32'h0, 4'hF, 0, 4, 1, 32'h5A5A, 32'h5A5A, 32'h5A5A, 1, 32'hE00, 5);
    set_mem(hv.addr, hv.init);
    mem_lat = hv.lat;
    exp_q.push_back(hv.exp_rd);
    drive(hv);
    @(posedge i_clk);
    #1 i_bus_en = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
      if (o_ack) got = 1'b1;
    end
    chk("drop_en_ack", got, 1'b1);
    @(negedge i_clk);

    // reset during AMO_WR aborts the AMO and wipes both reservations
    run(mk("lr_f00_id0", 1, LR, 0, 32'hF00, 32'h0, 4'h0, 0, 1, 1, 32'hF0, 32'hF0, 32'hF0, 1, 32'hF00, 2));
    run(mk("lr_f04_id1", 1, LR, 0, 32'hF04, 32'h0, 4'h0, 1, 1, 1, 32'hF4, 32'hF4, 32'hF4, 1, 32'hF04, 2));
    hv = mk("amo_rst", 1, ADD, 0, 32'hF08, 32'h5, 4'h0, 0, 4, 1, 32'hA, 32'h0, 32'h0, 0, 32'h0, 0);
    set_mem(hv.addr, hv.init);
    mem_lat = hv.lat;
    drive(hv);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
      if (o_mem_en && o_mem_wr) got = 1'b1;
    end
    chk("amo_reached_write", got, 1'b1);
    ack0 = ack_cnt;
    #2 i_rst = 1'b0;
    #1 chk("reset_async_outputs",
           {o_ack, o_mem_en, o_mem_wr, o_rd_data, o_mem_addr, o_mem_wr_data, o_mem_byte_en}, '0);
    i_bus_en = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("no_ack_after_reset", ack_cnt - ack0, 0);
    chk("amo_word_untouched", rd_mem(32'hF08), 32'hA);
    run(mk("sc_f00_rst", 1, SC, 0, 32'hF00, 32'h1, 4'h0, 0, 1, 0, 32'h0, 32'h1, 32'hF0, 0, 32'h0, 2));
    run(mk("sc_f04_rst", 1, SC, 0, 32'hF04, 32'h1, 4'h0, 1, 1, 0, 32'h0, 32'h1, 32'hF4, 0, 32'h0, 2));
    run(mk("rd_after_rst", 0, ADD, 0, 32'hF08, 32'h0, 4'hF, 1, 2, 0, 32'h0, 32'hA, 32'hA, 1, 32'hF08, 3));

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000 ns, expected completion");
    $fatal(1);
  end

endmodule
